imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//   Hardware counterpart of the bench-side instruction preload: fills the core's
//   instruction memory from a byte stream (UART RX or debug link) at boot.
//   Holds the riscv core in reset while loading and releases it when the image is complete.
//   Sits between the byte source, the instruction memory write port and the core reset.
// PARAMETERS
//   ADDR_W   8   instruction memory word-address width; capacity 2**ADDR_W words
// PORTS
//   clk         in   1       system clock
//   rst         in   1       asynchronous, active-high reset
//   start       in   1       1-cycle pulse: begin a new load
//   rx_data     in   8       stream byte
//   rx_valid    in   1       rx_data valid
//   rx_ready    out  1       loader accepts the byte this cycle
//   mem_we      out  1       instruction memory write enable, 1-cycle pulse
//   mem_addr    out  ADDR_W  word address of the write
//   mem_wdata   out  32      instruction word
//   core_rst_n  out  1       active-low reset to the core; 0 while loading
//   busy        out  1       load in progress
//   done        out  1       level: last load completed OK
//   err         out  1       level: last load rejected (length too large)
// BEHAVIOUR
//   Reset (async): state IDLE. rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0,
//     done=0, err=0, core_rst_n=0. The core stays in reset until the first successful load.
//   Handshake: a byte is consumed only on rx_valid && rx_ready. rx_data is sampled only then.
//     rx_valid may drop at any time. Gaps of any length are legal.
//   Stream format: N[7:0], N[15:8] (16-bit word count N, little-endian),
//     then 4*N bytes, each word little-endian (first byte = bits 7:0).
//   States: IDLE, LEN0, LEN1, DATA, DONE, ERR.
//     IDLE/DONE/ERR + start -> LEN0. Entering LEN0 sets busy=1, done=0, err=0 and core_rst_n=0.
//     start while busy is ignored.
//     LEN0: rx_ready=1. Accepted byte -> N[7:0], then LEN1.
//     LEN1: rx_ready=1. Accepted byte -> N[15:8], then:
//       N==0         -> DONE
//       N>2**ADDR_W  -> ERR
//       else         -> DATA, with word index=0 and byte count=0
//     DATA: rx_ready=1. Each accepted byte shifts into the assembly register.
//       On the 4th byte, the cycle after the handshake has mem_we=1 with mem_addr=word index
//       and mem_wdata=assembled word. Then the word index increments.
//       rx_ready stays 1 during the write cycle, so full throughput is 1 byte/cycle.
//       After the write of word N-1 -> DONE in the following cycle.
//     DONE: busy=0, done=1, core_rst_n=1, rx_ready=0.
//     ERR: busy=0, err=1, core_rst_n=0, rx_ready=0. No writes are issued.
//   mem_we is never asserted outside DATA. Each address 0..N-1 is written exactly once.
//     Outside a write, mem_addr and mem_wdata hold their last value.
//   Bytes presented while rx_ready=0 are not consumed.
//   rst mid-load: all outputs return immediately to their reset values. Memory already
//     written is not cleared. A new start restarts from LEN0.
//   N==2**ADDR_W is legal: the last write goes to address 2**ADDR_W-1, with no wrap.
// TESTING
//   1 Assert rst -> all outputs 0 (core_rst_n=0). Release rst -> still 0 until a load.
//   2 start, then bytes 02 00 93 00 10 00 13 01 20 00 back-to-back ->
//     writes [0]=0x00100093 and [1]=0x00200113. Next cycle: done=1, core_rst_n=1, busy=0.
//     The core then runs so that x1=1 and x2=2.
//   3 Same stream with random rx_valid gaps and a start pulse mid-load ->
//     identical writes, same order, no extra mem_we.
//   4 Bytes 00 00 -> no mem_we. DONE the cycle after the 2nd byte.
//   5 ADDR_W=8, bytes 01 01 (N=257) -> err=1, core_rst_n=0, no writes.
//     A following valid load clears err.
//   6 rst asserted after 5 data bytes -> outputs reset asynchronously.
//     A restarted load of test 2 completes correctly.

Source files
------------

// File: rtl/imem_boot_loader_if.sv
// Byte-stream, instruction-memory write and core-reset bundle of the boot loader.
// slave = loader side, master = byte source / memory / observer side.
interface imem_boot_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_rst_n;
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  start, rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata, core_rst_n, busy, done, err
  );

  modport master (
    output start, rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata, core_rst_n, busy, done, err
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot-time instruction memory loader: parses a length-prefixed little-endian byte
// stream, writes one word per 4 bytes and holds the core in reset until the image is in.
module imem_boot_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  imem_boot_loader_if.slave   bus
);

  localparam int unsigned IDX_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 32'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_DONE, S_ERR
  } state_t;

  state_t              r_state,      w_state_nxt;
  logic                r_rx_ready,   w_rx_ready_nxt;
  logic                r_mem_we,     w_mem_we_nxt;
  logic [ADDR_W-1:0]   r_mem_addr,   w_mem_addr_nxt;
  logic [31:0]         r_mem_wdata,  w_mem_wdata_nxt;
  logic                r_core_rst_n, w_core_rst_n_nxt;
  logic                r_busy,       w_busy_nxt;
  logic                r_done,       w_done_nxt;
  logic                r_err,        w_err_nxt;
  logic [15:0]         r_len,        w_len_nxt;
  logic [IDX_W-1:0]    r_word_idx,   w_word_idx_nxt;
  logic [1:0]          r_byte_cnt,   w_byte_cnt_nxt;
  logic [31:0]         r_asm,        w_asm_nxt;

  logic                w_accept;
  logic [15:0]         w_len_full;
  logic                w_last_word;
  logic                w_all_written;

  assign w_accept      = bus.rx_valid && r_rx_ready;
  assign w_len_full    = {bus.rx_data, r_len[7:0]};
  assign w_last_word   = (16'(r_word_idx) + 16'd1) == r_len;
  assign w_all_written = 16'(r_word_idx) == r_len;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rx_ready   <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_core_rst_n <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_len        <= '0;
      r_word_idx   <= '0;
      r_byte_cnt   <= '0;
      r_asm        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_rx_ready   <= w_rx_ready_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_core_rst_n <= w_core_rst_n_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_err        <= w_err_nxt;
      r_len        <= w_len_nxt;
      r_word_idx   <= w_word_idx_nxt;
      r_byte_cnt   <= w_byte_cnt_nxt;
      r_asm        <= w_asm_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt      = r_state;
    w_rx_ready_nxt   = 1'b0;
    w_mem_we_nxt     = 1'b0;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_core_rst_n_nxt = r_core_rst_n;
    w_busy_nxt       = r_busy;
    w_done_nxt       = r_done;
    w_err_nxt        = r_err;
    w_len_nxt        = r_len;
    w_word_idx_nxt   = r_word_idx;
    w_byte_cnt_nxt   = r_byte_cnt;
    w_asm_nxt        = r_asm;

    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.start) begin
          w_state_nxt      = S_LEN0;
          w_rx_ready_nxt   = 1'b1;
          w_busy_nxt       = 1'b1;
          w_done_nxt       = 1'b0;
          w_err_nxt        = 1'b0;
          w_core_rst_n_nxt = 1'b0;
        end
      end

      S_LEN0: begin
        w_rx_ready_nxt = 1'b1;
        if (w_accept) begin
          w_len_nxt   = {8'h00, bus.rx_data};
          w_state_nxt = S_LEN1;
        end
      end

      S_LEN1: begin
        w_rx_ready_nxt = 1'b1;
        if (w_accept) begin
          w_len_nxt = w_len_full;
          if (w_len_full == 16'd0) begin
            w_state_nxt      = S_DONE;
            w_rx_ready_nxt   = 1'b0;
            w_busy_nxt       = 1'b0;
            w_done_nxt       = 1'b1;
            w_core_rst_n_nxt = 1'b1;
          end else if (32'(w_len_full) > DEPTH) begin
            w_state_nxt    = S_ERR;
            w_rx_ready_nxt = 1'b0;
            w_busy_nxt     = 1'b0;
            w_err_nxt      = 1'b1;
          end else begin
            w_state_nxt    = S_DATA;
            w_word_idx_nxt = '0;
            w_byte_cnt_nxt = '0;
          end
        end
      end

      S_DATA: begin
        w_rx_ready_nxt = 1'b1;
        if (r_mem_we && w_all_written) begin
          w_state_nxt      = S_DONE;
          w_rx_ready_nxt   = 1'b0;
          w_busy_nxt       = 1'b0;
          w_done_nxt       = 1'b1;
          w_core_rst_n_nxt = 1'b1;
        end else if (w_accept) begin
          w_asm_nxt      = {bus.rx_data, r_asm[31:8]};
          w_byte_cnt_nxt = r_byte_cnt + 2'd1;
          if (r_byte_cnt == 2'd3) begin
            w_mem_we_nxt    = 1'b1;
            w_mem_addr_nxt  = r_word_idx[ADDR_W-1:0];
            w_mem_wdata_nxt = {bus.rx_data, r_asm[31:8]};
            w_word_idx_nxt  = r_word_idx + IDX_W'(1);
            // No byte is wanted during the final write cycle.
            if (w_last_word) w_rx_ready_nxt = 1'b0;
          end
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.rx_ready   = r_rx_ready;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.core_rst_n = r_core_rst_n;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed and randomized image streams
// compared against a word-level model of the expected memory writes.
`timescale 1ns/1ps
module tb_imem_boot_loader;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;

  imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  tx_q[$];
  logic [39:0] wr_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Write monitor: every mem_we cycle logged as {addr, data}
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) wr_q.push_back({bus.mem_addr, bus.mem_wdata});
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdy"},  32'(bus.rx_ready),   32'd0);
    chk({tag, "_we"},   32'(bus.mem_we),     32'd0);
    chk({tag, "_addr"}, 32'(bus.mem_addr),   32'd0);
    chk({tag, "_wd"},   bus.mem_wdata,       32'd0);
    chk({tag, "_core"}, 32'(bus.core_rst_n), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy),       32'd0);
    chk({tag, "_done"}, 32'(bus.done),       32'd0);
    chk({tag, "_err"},  32'(bus.err),        32'd0);
  endtask

  // Present one byte after `gap` idle cycles; returns at the negedge after acceptance
  task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse_start);
    int n;
    for (int g = 0; g < gap; g++) begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
      @(negedge clk);
    end
    if (pulse_start) begin
      bus.rx_valid = 1'b0;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start    = 1'b0;
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    n = 0;
    while (bus.rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("byte_accept", 32'(bus.rx_ready), 32'd1);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  function automatic logic [31:0] model_word(input int k);
    logic [31:0] w;
    w = 32'd0;
    for (int j = 0; j < 4; j++) w = w + (32'(tx_q[2 + 4*k + j]) << (8*j));
    return w;
  endfunction

  // Full load of tx_q, then compare status and the write log with the model
  task automatic run_load(input int maxgap, input bit mid_start);
    int n;
    int exp_words;
    wr_q.delete();
    pulse_start();
    chk("len0_busy", 32'(bus.busy),       32'd1);
    chk("len0_done", 32'(bus.done),       32'd0);
    chk("len0_err",  32'(bus.err),        32'd0);
    chk("len0_core", 32'(bus.core_rst_n), 32'd0);
    foreach (tx_q[k])
      send_byte(tx_q[k], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0,
                mid_start && (k == 6 || k == 1));
    n = 32'({tx_q[1], tx_q[0]});
    if (n == 0) begin
      chk("n0_done", 32'(bus.done),       32'd1);
      chk("n0_core", 32'(bus.core_rst_n), 32'd1);
      chk("n0_busy", 32'(bus.busy),       32'd0);
    end else if (n > int'(DEPTH)) begin
      chk("big_err",  32'(bus.err),        32'd1);
      chk("big_core", 32'(bus.core_rst_n), 32'd0);
      chk("big_busy", 32'(bus.busy),       32'd0);
      chk("big_done", 32'(bus.done),       32'd0);
    end else begin
      chk("last_we",   32'(bus.mem_we),   32'd1);
      chk("last_addr", 32'(bus.mem_addr), 32'(n - 1));
      chk("last_done", 32'(bus.done),     32'd0);
      @(negedge clk);
      chk("fin_done", 32'(bus.done),       32'd1);
      chk("fin_core", 32'(bus.core_rst_n), 32'd1);
      chk("fin_busy", 32'(bus.busy),       32'd0);
      chk("fin_we",   32'(bus.mem_we),     32'd0);
      chk("fin_rdy",  32'(bus.rx_ready),   32'd0);
    end
    @(negedge clk);
    exp_words = (n >= 1 && n <= int'(DEPTH)) ? n : 0;
    chk("n_writes", 32'(wr_q.size()), 32'(exp_words));
    for (int k = 0; k < exp_words && k < wr_q.size(); k++) begin
      chk("wr_addr", 32'(wr_q[k][39:32]), 32'(k));
      chk("wr_data", wr_q[k][31:0], model_word(k));
    end
  endtask

  task automatic load_test2();
    tx_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
  endtask

  task automatic load_random(input int n);
    tx_q.delete();
    tx_q.push_back(8'(n));
    tx_q.push_back(8'(n >> 8));
    if (n <= int'(DEPTH))
      for (int i = 0; i < 4*n; i++) tx_q.push_back(8'($urandom));
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    // Reset values, during and after reset
    #12;
    chk_all_zero("rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("post_rst");

    // Directed two-word image, back-to-back bytes
    load_test2();
    run_load(0, 1'b0);
    chk("t2_w0", model_word(0), 32'h00100093);
    chk("t2_w1", model_word(1), 32'h00200113);

    // Same image with gaps and ignored start pulses
    run_load(4, 1'b1);

    // Bytes offered while idle must not be consumed
    wr_q.delete();
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h55;
    repeat (5) @(negedge clk);
    bus.rx_valid = 1'b0;
    chk("idle_rdy", 32'(bus.rx_ready), 32'd0);
    chk("idle_nowr", 32'(wr_q.size()), 32'd0);

    // Empty image
    load_random(0);
    run_load(2, 1'b0);

    // Oversized image rejected, then cleared by a valid load
    load_random(257);
    run_load(0, 1'b0);
    load_random(3);
    run_load(1, 1'b0);
    chk("err_cleared", 32'(bus.err), 32'd0);

    // Full-capacity image
    load_random(int'(DEPTH));
    run_load(0, 1'b0);

    // Randomized images
    for (int t = 0; t < 6; t++) begin
      load_random(int'($urandom_range(1, 9)));
      run_load(int'($urandom_range(0, 3)), t[0]);
    end

    // Reset mid-load after 5 data bytes, then a clean restart
    load_test2();
    pulse_start();
    for (int k = 0; k < 7; k++) send_byte(tx_q[k], 0, 1'b0);
    #2 rst = 1'b1;
    #1 chk_all_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_core", 32'(bus.core_rst_n), 32'd0);
    run_load(0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
